lane_mover: RTL and testbench

Initiator for the 5x5x64 lane-memory interface used by the permutation block. Accepts a 25-lane state over a valid/ready input stream and writes it into the lane memory. Reads a 25-lane state back out onto a valid/ready output stream. Sits between the bus-facing logic and the lane memory, and drives that memory's read-address, write-address, write-enable and write-data ports.

---
 rtl/lane_pkg.sv | 19 +
 rtl/lane_cnt.sv | 37 +++
 rtl/lane_mover.sv | 134 +++++++++++++
 tb/tb_lane_mover.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared types and constants for the 5x5x64 lane-memory datapath.
package lane_pkg;

  localparam int unsigned LANE_W   = 64;
  localparam int unsigned LANE_DIM = 5;
  localparam int unsigned LANE_CNT = LANE_DIM * LANE_DIM;
  localparam int unsigned COORD_W  = 3;

  typedef logic [LANE_W-1:0]  lane_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mover_state_e;

endpackage

// File: rtl/lane_cnt.sv
// x-fastest lane address counter over a DIM x DIM grid; wraps (DIM-1,DIM-1) -> (0,0).
module lane_cnt
  import lane_pkg::*;
#(
  parameter int unsigned DIM = LANE_DIM
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   inc,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  localparam coord_t MAXC = coord_t'(DIM - 1);

  assign last = (x == MAXC) && (y == MAXC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == MAXC) begin
        x <= '0;
        y <= (y == MAXC) ? '0 : y + coord_t'(1);
      end else begin
        x <= x + coord_t'(1);
      end
    end
  end

endmodule

// File: rtl/lane_mover.sv
// Streams a 25-lane state into / out of the lane memory over valid/ready.
// Define LANE_MOVER_ABSORB_EN to XOR incoming lanes with memory contents on load.
module lane_mover
  import lane_pkg::*;
#(
  parameter int unsigned W   = LANE_W,
  parameter int unsigned DIM = LANE_DIM
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_load,
  input  logic         start_drain,
  output logic         busy,
  output logic         done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   rx,
  output logic [2:0]   ry,
  input  logic [W-1:0] rd,
  output logic [2:0]   wx,
  output logic [2:0]   wy,
  output logic         wr,
  output logic [W-1:0] wd
);

  mover_state_e state, state_nxt;

  coord_t lx, ly, fx, fy;
  logic   l_last, f_last;
  logic   start_ok, load_inc, fetch_inc, fetch_all, drain_end;

  lane_cnt #(.DIM(DIM)) u_load_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_ok),
    .inc  (load_inc),
    .x    (lx),
    .y    (ly),
    .last (l_last)
  );

  lane_cnt #(.DIM(DIM)) u_fetch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_ok),
    .inc  (fetch_inc),
    .x    (fx),
    .y    (fy),
    .last (f_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Load has priority over drain when both starts arrive together.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_load)       state_nxt = ST_LOAD;
        else if (start_drain) state_nxt = ST_DRAIN;
      end
      ST_LOAD:  if (load_inc && l_last) state_nxt = ST_DONE;
      ST_DRAIN: if (drain_end)          state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ok  = 1'b0;
    load_inc  = 1'b0;
    fetch_inc = 1'b0;
    drain_end = 1'b0;
    wr        = 1'b0;
    wd        = '0;
    wx        = lx;
    wy        = ly;
    rx        = lx;
    ry        = ly;
    case (state)
      ST_IDLE: start_ok = start_load | start_drain;
      ST_LOAD: begin
        load_inc = in_valid & in_ready;
        if (load_inc) begin
          wr = 1'b1;
`ifdef LANE_MOVER_ABSORB_EN
          wd = in_data ^ rd;
`else
          wd = in_data;
`endif
        end
      end
      ST_DRAIN: begin
        rx        = fx;
        ry        = fy;
        fetch_inc = (!out_valid || out_ready) && !fetch_all;
        drain_end = out_valid && out_ready && fetch_all;
      end
      default: ;
    endcase
  end

  // fetch_all marks that the last lane is already in (or past) the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      fetch_all <= 1'b0;
    end else begin
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
      in_ready <= (state_nxt == ST_LOAD);
      if (fetch_inc) begin
        out_data  <= rd;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state != ST_DRAIN)        fetch_all <= 1'b0;
      else if (fetch_inc && f_last) fetch_all <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_mover.sv
// Self-checking bench for lane_mover with a behavioural lane memory and reference contents.
module tb_lane_mover;
  import lane_pkg::*;

`ifdef LANE_MOVER_ABSORB_EN
  localparam bit ABSORB = 1'b1;
`else
  localparam bit ABSORB = 1'b0;
`endif
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_load = 1'b0, start_drain = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  lane_t      in_data = '0;
  logic       busy, done, in_ready, out_valid, wr;
  lane_t      out_data, rd, wd;
  logic [2:0] rx, ry, wx, wy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lane_mover #(.W(LANE_W), .DIM(LANE_DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_drain(start_drain),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rx(rx), .ry(ry), .rd(rd), .wx(wx), .wy(wy), .wr(wr), .wd(wd)
  );

  // Lane memory: combinational read, write on clk edge, never reset.
  lane_t mem [LANE_CNT];
  logic  preload_en = 1'b0;
  lane_t preload_val = '0;

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < LANE_CNT; i++) mem[i] <= preload_val;
    end else if (wr && wx < 3'd5 && wy < 3'd5) begin
      mem[int'(wy) * 5 + int'(wx)] <= wd;
    end
  end

  assign rd = (rx < 3'd5 && ry < 3'd5) ? mem[int'(ry) * 5 + int'(rx)] : '0;

  // Reference: what each lane (index 5y+x) should hold, and lanes to load next.
  lane_t ref_mem [LANE_CNT];
  lane_t load_vals [LANE_CNT];

  typedef struct {
    logic sl, sd, iv;
    logic e_busy, e_ready, e_done, e_wr;
  } vec_t;
  vec_t vt [4];

  task automatic check(input string name, input lane_t act, input lane_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic preload(input lane_t v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
    for (int i = 0; i < LANE_CNT; i++) ref_mem[i] = v;
  endtask

  task automatic start_op(input logic ld, input logic dr);
    start_load  = ld;
    start_drain = dr;
    @(negedge clk);
    start_load  = 1'b0;
    start_drain = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_in_ready"}, in_ready, 1'b0);
    check_bit({tag, "_out_valid"}, out_valid, 1'b0);
    check_bit({tag, "_wr"}, wr, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_wd"}, wd, '0);
    check({tag, "_addr"}, lane_t'({rx, ry, wx, wy}), '0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < LANE_CNT; i++) check(tag, mem[i], ref_mem[i]);
  endtask

  // Feeds lanes 0..n-1; returns the number of cycles spent.
  task automatic load_stream(input int n, input int stall_pct, input bit noise, output int cyc);
    int    idx = 0;
    lane_t exp;
    cyc = 0;
    while (idx < n && cyc < TMO) begin
      in_valid = (int'($urandom_range(99)) >= stall_pct);
      in_data  = in_valid ? load_vals[idx] : {$urandom, $urandom};
      if (noise) start_drain = 1'($urandom_range(1));
      #1;
      check_bit("load_in_ready", in_ready, 1'b1);
      check_bit("load_wr", wr, in_valid);
      if (in_valid) begin
        exp = ABSORB ? (load_vals[idx] ^ ref_mem[idx]) : load_vals[idx];
        check("load_wd", wd, exp);
        check("load_waddr", lane_t'({wy, wx}), lane_t'({3'(idx / 5), 3'(idx % 5)}));
        ref_mem[idx] = exp;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid    = 1'b0;
    start_drain = 1'b0;
    if (cyc >= TMO) check_bit("load_timeout", 1'b1, 1'b0);
  endtask

  task automatic load_body(input int stall_pct, input bit noise);
    int cyc;
    load_stream(LANE_CNT, stall_pct, noise, cyc);
    if (stall_pct == 0) check("load_cycles", lane_t'(cyc), lane_t'(LANE_CNT));
    #1;
    check_bit("load_done", done, 1'b1);
    check_bit("load_done_busy", busy, 1'b1);
    check_bit("load_done_ready", in_ready, 1'b0);
    check_bit("load_done_wr", wr, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("post_load_done", done, 1'b0);
      check_bit("post_load_busy", busy, 1'b0);
      check_bit("post_load_wr", wr, 1'b0);
      check("post_load_addr", lane_t'({rx, ry, wx, wy}), '0);
    end
    check_mem("load_mem");
  endtask

  task automatic run_load(input int stall_pct, input bit noise);
    start_op(1'b1, 1'b0);
    check_bit("load_busy", busy, 1'b1);
    load_body(stall_pct, noise);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic run_drain(input int mode);
    int    beat = 0;
    int    cyc = 0;
    bit    hold = 1'b0;
    lane_t hold_data = '0;
    start_op(1'b0, 1'b1);
    check_bit("drain_busy", busy, 1'b1);
    while (beat < LANE_CNT && cyc < TMO) begin
      if (hold) begin
        check_bit("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_data);
      end
      if (mode == 0 && cyc == 0) check_bit("drain_first_valid", out_valid, 1'b0);
      if (mode == 0 && cyc == 1) check_bit("drain_second_valid", out_valid, 1'b1);
      check_bit("drain_wr", wr, 1'b0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      if (out_valid && out_ready) begin
        check("drain_beat", out_data, ref_mem[beat]);
        beat++;
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= TMO) check_bit("drain_timeout", 1'b1, 1'b0);
    if (mode == 0) check("drain_cycles", lane_t'(cyc), lane_t'(LANE_CNT + 1));
    check_bit("drain_done", done, 1'b1);
    check_bit("drain_done_valid", out_valid, 1'b0);
    @(negedge clk);
    check_bit("post_drain_done", done, 1'b0);
    check_bit("post_drain_busy", busy, 1'b0);
    check("post_drain_addr", lane_t'({rx, ry}), '0);
  endtask

  initial begin
    int cyc;

    vt[0] = '{sl: 1'b1, sd: 1'b1, iv: 1'b0, e_busy: 1'b0, e_ready: 1'b0, e_done: 1'b0, e_wr: 1'b0};
    vt[1] = '{sl: 1'b0, sd: 1'b1, iv: 1'b0, e_busy: 1'b1, e_ready: 1'b1, e_done: 1'b0, e_wr: 1'b0};
    vt[2] = '{sl: 1'b1, sd: 1'b0, iv: 1'b0, e_busy: 1'b1, e_ready: 1'b1, e_done: 1'b0, e_wr: 1'b0};
    vt[3] = '{sl: 1'b0, sd: 1'b0, iv: 1'b0, e_busy: 1'b1, e_ready: 1'b1, e_done: 1'b0, e_wr: 1'b0};

    #1;
    check_all_zero("reset");
    preload('0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Incrementing pattern, full throughput, then drains under two ready patterns.
    for (int i = 0; i < LANE_CNT; i++) load_vals[i] = 64'h1000 + lane_t'(i);
    run_load(0, 1'b0);
    for (int i = 0; i < LANE_CNT; i++) check("pattern_lane", mem[i], 64'h1000 + lane_t'(i));
    run_drain(0);
    run_drain(1);

    // Simultaneous starts pick load; drain starts during load are ignored.
    for (int i = 0; i < LANE_CNT; i++) load_vals[i] = 64'h2000 + lane_t'(i * 7);
    for (int v = 0; v < 4; v++) begin
      check_bit("vec_busy", busy, vt[v].e_busy);
      check_bit("vec_ready", in_ready, vt[v].e_ready);
      check_bit("vec_done", done, vt[v].e_done);
      start_load  = vt[v].sl;
      start_drain = vt[v].sd;
      in_valid    = vt[v].iv;
      #1;
      check_bit("vec_wr", wr, vt[v].e_wr);
      @(negedge clk);
    end
    start_load  = 1'b0;
    start_drain = 1'b0;
    load_body(30, 1'b1);
    run_drain(2);

    // Reset after 10 lanes: outputs clear at once, written lanes stay, rest untouched.
    for (int i = 0; i < LANE_CNT; i++) load_vals[i] = 64'hA000_0000_0000_0000 + lane_t'(i);
    start_op(1'b1, 1'b0);
    load_stream(10, 0, 1'b0, cyc);
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    rst_n    = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check_mem("midreset_mem");
    run_load(0, 1'b0);
    run_drain(0);

    // Random lanes with random stalls and back-pressure.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LANE_CNT; i++) load_vals[i] = {$urandom, $urandom};
      run_load(int'($urandom_range(60)), 1'b1);
      run_drain(2);
    end

`ifdef LANE_MOVER_ABSORB_EN
    preload(64'hFFFF_0000_FFFF_0000);
    for (int i = 0; i < LANE_CNT; i++) load_vals[i] = 64'h0F0F_0F0F_0F0F_0F0F;
    run_load(0, 1'b0);
    for (int i = 0; i < LANE_CNT; i++) check("absorb_lane", mem[i], 64'hF0F0_0F0F_F0F0_0F0F);
    run_drain(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
